// File: rtl/spiker_collector.sv
// -----------------------------------------------------------------------------
// spiker_collector
//
// Upstream stage of the spiker result writer. Collects the spiking core's
// output spike vector, delivered as a stream of WIDTH-bit words, into a single
// DATA_WIDTH-bit frame. When a frame completes it is presented on data_out_o
// together with a one-cycle sample_o pulse, which the result writer uses to
// capture data_out_o.
//
// Handshake: a stream word (spike_data_i / spike_last_i) is transferred on
// every rising clk_i edge where spike_valid_i and spike_ready_o are both high.
// spike_ready_o is registered and only depends on the FSM state, never on
// spike_valid_i.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous, active-high reset (highest priority)
//   start_i        arms capture of one frame; only honoured in IDLE
//   spike_data_i   stream word, WIDTH bits
//   spike_valid_i  spike_data_i / spike_last_i are valid
//   spike_last_i   marks the final word of a frame
//   spike_ready_o  collector accepts a word this cycle
//   data_out_o     last completed frame, stable between sample_o pulses
//   sample_o       one-cycle pulse, data_out_o valid in the same cycle
//   busy_o         high in COLLECT and DONE
//   error_o        sticky framing error
//
// Build option:
//   SPIKER_COLLECTOR_AUTORESTART_EN  when defined, DONE returns straight to
//   COLLECT so frames stream continuously after a single start_i; error_o is
//   then cleared only by rst_i. When undefined, DONE returns to IDLE and each
//   frame needs its own start_i, which also clears error_o.
// -----------------------------------------------------------------------------
module spiker_collector #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 800
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      spike_data_i,
  input  logic                  spike_valid_i,
  input  logic                  spike_last_i,
  output logic                  spike_ready_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  sample_o,
  output logic                  busy_o,
  output logic                  error_o
);

  // Number of stream words per frame (rounded up) and width of the final,
  // possibly partial, slot.
  localparam int N_WORDS = (DATA_WIDTH + WIDTH - 1) / WIDTH;
  localparam int LAST_W  = DATA_WIDTH - (N_WORDS - 1) * WIDTH;
  // One extra bit so the counter can reach N_WORDS without wrapping.
  localparam int CNT_W   = $clog2(N_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                  state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0]   buf_q,    buf_d;
  logic [DATA_WIDTH-1:0]   data_q,   data_d;
  logic                    sample_q, sample_d;
  logic                    ready_q,  ready_d;
  logic                    busy_q,   busy_d;
  logic                    error_q,  error_d;

  logic                    accept;
  logic                    slot_last;
  logic                    frame_end;
  logic                    frame_err;
  logic [DATA_WIDTH-1:0]   merged;

  // A transfer can only happen in COLLECT; ready_q already implies that, the
  // explicit state term keeps the intent obvious.
  assign accept    = (state_q == S_COLLECT) && ready_q && spike_valid_i;
  assign slot_last = (cnt_q == LAST_IDX);
  assign frame_end = accept && (slot_last || spike_last_i);
  // Last flag early, or missing on the final slot.
  assign frame_err = accept && (spike_last_i != slot_last);

  // Assembly buffer with the incoming word dropped into slot cnt_q. The final
  // slot keeps only its LAST_W low bits; the rest of that word is discarded.
  always_comb begin
    merged = buf_q;
    for (int i = 0; i < N_WORDS - 1; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        merged[i*WIDTH +: WIDTH] = spike_data_i;
      end
    end
    if (slot_last) begin
      merged[DATA_WIDTH-1 -: LAST_W] = spike_data_i[LAST_W-1:0];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    data_d   = data_q;
    sample_d = 1'b0;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          buf_d   = '0;
`ifndef SPIKER_COLLECTOR_AUTORESTART_EN
          error_d = 1'b0;
`endif
        end
      end

      S_COLLECT: begin
        if (accept) begin
          buf_d = merged;
          cnt_d = cnt_q + 1'b1;
          if (frame_err) begin
            error_d = 1'b1;
          end
          if (frame_end) begin
            // Unwritten slots are still zero from the clear on entry.
            data_d   = merged;
            sample_d = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
`ifdef SPIKER_COLLECTOR_AUTORESTART_EN
        state_d = S_COLLECT;
        cnt_d   = '0;
        buf_d   = '0;
`else
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake and status flags are registered decodes of the next state.
    ready_d = (state_d == S_COLLECT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      data_q   <= '0;
      sample_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      data_q   <= data_d;
      sample_q <= sample_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign spike_ready_o = ready_q;
  assign data_out_o    = data_q;
  assign sample_o      = sample_q;
  assign busy_o        = busy_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_spiker_collector.sv
// -----------------------------------------------------------------------------
// tb_spiker_collector
//
// Directed bench for spiker_collector. Instance dut_a uses the default
// geometry (32-bit words, 800-bit frame, 25 words); instance dut_b uses an
// 80-bit frame so the truncated final slot can be observed. Inputs are driven
// 1 ns after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_spiker_collector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: defaults ----------------
  logic         start_a = 1'b0;
  logic [31:0]  data_a  = '0;
  logic         valid_a = 1'b0;
  logic         last_a  = 1'b0;
  logic         ready_a;
  logic [799:0] dout_a;
  logic         sample_a;
  logic         busy_a;
  logic         error_a;

  spiker_collector dut_a (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_a),
    .spike_data_i  (data_a),
    .spike_valid_i (valid_a),
    .spike_last_i  (last_a),
    .spike_ready_o (ready_a),
    .data_out_o    (dout_a),
    .sample_o      (sample_a),
    .busy_o        (busy_a),
    .error_o       (error_a)
  );

  // ---------------- DUT B: 80-bit frame ----------------
  logic        start_b = 1'b0;
  logic [31:0] data_b  = '0;
  logic        valid_b = 1'b0;
  logic        last_b  = 1'b0;
  logic        ready_b;
  logic [79:0] dout_b;
  logic        sample_b;
  logic        busy_b;
  logic        error_b;

  spiker_collector #(.WIDTH(32), .DATA_WIDTH(80)) dut_b (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_b),
    .spike_data_i  (data_b),
    .spike_valid_i (valid_b),
    .spike_last_i  (last_b),
    .spike_ready_o (ready_b),
    .data_out_o    (dout_b),
    .sample_o      (sample_b),
    .busy_o        (busy_b),
    .error_o       (error_b)
  );

  // ---------------- sample_o monitor (dut_a) ----------------
  int n_samp    = 0;
  int samp_prev = 0;
  int samp_last = 0;
  always @(negedge clk) begin
    if (sample_a) begin
      n_samp    = n_samp + 1;
      samp_prev = samp_last;
      samp_last = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [799:0] exp_q[$];

  task automatic check(input string tag, input logic [799:0] got, input logic [799:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word to dut_a and hold it until the edge that accepts it.
  task automatic send_a(input logic [31:0] d, input logic l);
    int n;
    valid_a = 1'b1;
    data_a  = d;
    last_a  = l;
    n = 0;
    while (!ready_a && n < 40) begin
      tick();
      n++;
    end
    if (!ready_a) check("ready_a_timeout", 1'b0, 1'b1);
    tick();
    valid_a = 1'b0;
    last_a  = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    valid_b = 1'b1;
    data_b  = d;
    last_b  = l;
    if (!ready_b) check("ready_b_low", 1'b0, 1'b1);
    tick();
    valid_b = 1'b0;
    last_b  = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [799:0] exp;
    int base;
    int k;
    int guard;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_dout",   dout_a,   '0);
    check("rst_sample", sample_a, 1'b0);
    check("rst_ready",  ready_a,  1'b0);
    check("rst_busy",   busy_a,   1'b0);
    check("rst_error",  error_a,  1'b0);
    rst = 1'b0;
    tick();
    check("idle_ready", ready_a, 1'b0);

`ifdef SPIKER_COLLECTOR_AUTORESTART_EN
    // Two frames back to back after a single start
    pulse_start_a();
    check("ar_ready_after_start", ready_a, 1'b1);
    exp = '0;
    for (int i = 0; i < 25; i++) begin
      send_a(32'h1000_0000 + i, i == 24);
      exp[i*32 +: 32] = 32'h1000_0000 + i;
    end
    exp_q.push_back(exp);
    check("ar_f1_sample", sample_a, 1'b1);
    check("ar_f1_data",   dout_a,   exp_q.pop_front());
    check("ar_f1_ready",  ready_a,  1'b0);
    exp = '0;
    for (int i = 0; i < 25; i++) begin
      send_a(32'h2000_0000 + i, i == 24);
      exp[i*32 +: 32] = 32'h2000_0000 + i;
    end
    exp_q.push_back(exp);
    check("ar_f2_sample", sample_a, 1'b1);
    check("ar_f2_data",   dout_a,   exp_q.pop_front());
    tick();
    check("ar_pulses",    n_samp, 2);
    check("ar_spacing",   samp_last - samp_prev, 26);
    check("ar_error",     error_a, 1'b0);
    check("ar_rearmed",   ready_a, 1'b1);
`else
    // Test 1: full frame, words 0..24, last on word 24
    pulse_start_a();
    check("t1_ready", ready_a, 1'b1);
    check("t1_busy",  busy_a,  1'b1);
    exp = '0;
    for (int i = 0; i < 25; i++) begin
      send_a(i, i == 24);
      exp[i*32 +: 32] = i;
    end
    exp_q.push_back(exp);
    check("t1_sample",   sample_a, 1'b1);
    check("t1_data",     dout_a,   exp_q.pop_front());
    check("t1_done_rdy", ready_a,  1'b0);
    check("t1_done_bsy", busy_a,   1'b1);
    check("t1_error",    error_a,  1'b0);
    tick();
    check("t1_sample_gone", sample_a, 1'b0);
    check("t1_idle_busy",   busy_a,   1'b0);
    check("t1_pulses",      n_samp,   1);
    tick();
    check("t1_stay_idle",   ready_a,  1'b0);
    check("t1_data_hold",   dout_a,   exp);

    // Test 2: 80-bit frame, final slot truncated to 16 bits
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    send_b(32'hAAAA_1111, 1'b0);
    send_b(32'hBBBB_2222, 1'b0);
    send_b(32'hCCCC_3333, 1'b1);
    check("t2_sample", sample_b, 1'b1);
    check("t2_data",   dout_b,   80'h3333_BBBB2222_AAAA1111);
    check("t2_error",  error_b,  1'b0);
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    send_b(32'h0102_0304, 1'b0);
    send_b(32'h0506_0708, 1'b0);
    send_b(32'hFFFF_9ABC, 1'b0);
    check("t2b_data",  dout_b,  80'h9ABC_05060708_01020304);
    check("t2b_error", error_b, 1'b1);

    // Test 3: early last on word 9
    pulse_start_a();
    exp = '0;
    for (int i = 0; i < 10; i++) begin
      send_a(32'hA500_0000 | i, i == 9);
      exp[i*32 +: 32] = 32'hA500_0000 | i;
    end
    exp_q.push_back(exp);
    check("t3_sample", sample_a, 1'b1);
    check("t3_data",   dout_a,   exp_q.pop_front());
    check("t3_upper",  dout_a[799:320], '0);
    check("t3_error",  error_a,  1'b1);
    tick();
    check("t3_sample_gone", sample_a, 1'b0);
    check("t3_error_stick", error_a,  1'b1);
    tick();
    check("t3_error_stick2", error_a, 1'b1);
    pulse_start_a();
    check("t3_error_clear", error_a, 1'b0);

    // Test 4: gappy valid plus start_i mid-frame (already in COLLECT)
    base = n_samp;
    exp  = '0;
    k    = 0;
    guard = 0;
    while (k < 25 && guard < 400) begin
      valid_a = 1'b0;
      last_a  = 1'b0;
      data_a  = $urandom_range(0, 32'h7fff_ffff);
      start_a = (k == 7 || k == 15);
      if ($urandom_range(0, 2) != 0) begin
        valid_a = 1'b1;
        data_a  = 32'hDEAD_0000 + k * 7;
        last_a  = (k == 24);
      end
      if (valid_a && ready_a) begin
        exp[k*32 +: 32] = 32'hDEAD_0000 + k * 7;
        k++;
      end
      tick();
      guard++;
    end
    valid_a = 1'b0;
    last_a  = 1'b0;
    start_a = 1'b0;
    check("t4_words_done", k, 25);
    exp_q.push_back(exp);
    check("t4_sample", sample_a, 1'b1);
    check("t4_data",   dout_a,   exp_q.pop_front());
    check("t4_error",  error_a,  1'b0);
    tick();
    check("t4_one_pulse", n_samp - base, 1);

    // Test 5: reset after word 12
    pulse_start_a();
    for (int i = 0; i < 13; i++) send_a(32'h5A5A_0000 + i, 1'b0);
    base    = n_samp;
    rst     = 1'b1;
    valid_a = 1'b1;
    data_a  = 32'h5A5A_000D;
    tick();
    check("t5_dout",   dout_a,   '0);
    check("t5_ready",  ready_a,  1'b0);
    check("t5_sample", sample_a, 1'b0);
    check("t5_busy",   busy_a,   1'b0);
    rst     = 1'b0;
    valid_a = 1'b0;
    tick();
    check("t5_no_pulse", n_samp - base, 0);
    pulse_start_a();
    exp = '0;
    for (int i = 0; i < 25; i++) begin
      send_a(32'h0F00_0000 + i * 3, i == 24);
      exp[i*32 +: 32] = 32'h0F00_0000 + i * 3;
    end
    exp_q.push_back(exp);
    check("t5_sample", sample_a, 1'b1);
    check("t5_data",   dout_a,   exp_q.pop_front());
    check("t5_error",  error_a,  1'b0);
    tick();
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
